// File: rtl/debounce_pkg.sv
// Shared constants and the counter-width helper for the debounce bank.
package debounce_pkg;

  localparam int unsigned DEF_THRESH   = 8;
  localparam int unsigned DEF_PRESCALE = 1000;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: input synchroniser, stability counter, debounced level
// and registered rise/fall pulses.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned THRESH      = DEF_THRESH,
  parameter logic        INIT_BIT    = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_i,
  input  logic tick_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic change_c
);

  localparam int unsigned             CNT_W   = cnt_w(THRESH);
  localparam logic [CNT_W-1:0]        CNT_MAX = CNT_W'(THRESH - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  assign s      = sync_q[SYNC_STAGES-1];
  assign sync_d = {sync_q[SYNC_STAGES-2:0], in_i};

  // A new level is accepted only after THRESH consecutive disagreeing ticks.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (tick_i) begin
      if (s == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        cnt_d   = '0;
        level_d = s;
        rise_d  = s;
        fall_d  = ~s;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= {SYNC_STAGES{INIT_BIT}};
      cnt_q   <= '0;
      level_q <= INIT_BIT;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o  = level_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign change_c = rise_d | fall_d;

endmodule

// File: rtl/debounce_bank.sv
// WIDTH-channel debouncer with a shared sample tick and change flag.
// Define DEBOUNCE_PRESCALE_EN to sample once every PRESCALE clocks.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter int unsigned      THRESH      = DEF_THRESH,
  parameter logic [WIDTH-1:0] INIT        = '0,
  parameter int unsigned      PRESCALE    = DEF_PRESCALE
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_in,
  output logic [WIDTH-1:0] o_level,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall,
  output logic             o_any_change
);

  logic             tick_c;
  logic [WIDTH-1:0] change_c;
  logic             any_q, any_d;

`ifdef DEBOUNCE_PRESCALE_EN
  localparam int unsigned      PS_W   = cnt_w(PRESCALE);
  localparam logic [PS_W-1:0]  PS_MAX = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_q, ps_d;

  // Free-running divider; the tick fires on its terminal count.
  always_comb begin
    tick_c = (ps_q == PS_MAX);
    ps_d   = tick_c ? '0 : ps_q + PS_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) ps_q <= '0;
    else          ps_q <= ps_d;
  end
`else
  // Sample every clock; PRESCALE has no effect in this build.
  assign tick_c = (PRESCALE != 0) || 1'b1;
`endif

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    debounce_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .THRESH     (THRESH),
      .INIT_BIT   (INIT[g])
    ) u_chan (
      .clk     (i_clk),
      .rst_n   (i_rst_n),
      .in_i    (i_in[g]),
      .tick_i  (tick_c),
      .level_o (o_level[g]),
      .rise_o  (o_rise[g]),
      .fall_o  (o_fall[g]),
      .change_c(change_c[g])
    );
  end

  assign any_d = |change_c;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) any_q <= 1'b0;
    else          any_q <= any_d;
  end

  assign o_any_change = any_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank: stimulus queues expected pulse events,
// a monitor pops and checks them whenever the DUT pulses.
module tb_debounce_bank;

  localparam int unsigned W = 4;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in_r  = '0;
  logic [W-1:0] o_level, o_rise, o_fall;
  logic         o_any_change;

  debounce_bank #(
    .WIDTH(W), .SYNC_STAGES(2), .THRESH(8), .INIT(4'h0), .PRESCALE(4)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in(in_r),
    .o_level(o_level), .o_rise(o_rise), .o_fall(o_fall),
    .o_any_change(o_any_change)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] level;
    logic [31:0]  lo;
    logic [31:0]  hi;
  } ev_t;

  ev_t          q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] lvl     = '0;
  int unsigned  c;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [W-1:0] r, input logic [W-1:0] f,
                      input int unsigned lo, input int unsigned hi);
    lvl = (lvl | r) & ~f;
    q.push_back('{rise: r, fall: f, level: lvl, lo: lo, hi: hi});
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain", q.size(), 0);
  endtask

  // Monitor: every pulse must match the oldest outstanding event.
  always @(negedge clk) begin
    ev_t e;
    if (o_any_change || (|o_rise) || (|o_fall)) begin
      if (q.size() == 0) begin
        check("unexpected_pulse", {o_rise, o_fall}, '0);
      end else begin
        e = q.pop_front();
        check("rise",       o_rise,       e.rise);
        check("fall",       o_fall,       e.fall);
        check("level",      o_level,      e.level);
        check("any_change", o_any_change, 1'b1);
        check("timing", ((cyc >= e.lo) && (cyc <= e.hi)) ? cyc : e.lo, e.lo);
      end
    end else if (q.size() != 0 && cyc > q[0].hi) begin
      e = q.pop_front();
      check("missed_event", {o_rise, o_fall}, {e.rise, e.fall});
    end
  end

  initial begin
`ifdef DEBOUNCE_PRESCALE_EN
    in_r = 4'h0;
    tick(3);
    check("rst_level", o_level, 4'h0);
    check("rst_any",   o_any_change, 1'b0);
    rst_n = 1'b1;
    tick(5);
    in_r[0] = 1'b1; c = cyc;
    push(4'h1, 4'h0, c + 2 + 7*4, c + 2 + 8*4 + 3);
    wait_idle(60);
    check("ps_level_hi", o_level, 4'h1);
    in_r[0] = 1'b0; c = cyc;
    push(4'h0, 4'h1, c + 2 + 7*4, c + 2 + 8*4 + 3);
    wait_idle(60);
    tick(10);
    check("ps_level_lo", o_level, 4'h0);
`else
    // Reset held with all inputs high: nothing moves.
    in_r = 4'hF;
    tick(3);
    check("rst_level", o_level, 4'h0);
    check("rst_rise",  o_rise,  4'h0);
    check("rst_fall",  o_fall,  4'h0);
    check("rst_any",   o_any_change, 1'b0);
    rst_n = 1'b1; c = cyc;
    push(4'hF, 4'h0, c + 10, c + 10);
    wait_idle(20);
    tick(3);
    in_r = 4'h0; c = cyc;
    push(4'h0, 4'hF, c + 10, c + 10);
    wait_idle(20);

    // Seven-sample glitch is rejected.
    in_r[0] = 1'b1;
    tick(7);
    in_r[0] = 1'b0;
    tick(15);
    check("glitch_level", o_level, 4'h0);

    // Eight samples are accepted; dropping afterwards falls eight samples later.
    in_r[0] = 1'b1; c = cyc;
    tick(8);
    in_r[0] = 1'b0;
    push(4'h1, 4'h0, c + 10, c + 10);
    push(4'h0, 4'h1, c + 18, c + 18);
    wait_idle(30);

    // Bouncing release on ch1 yields a single fall.
    in_r[1] = 1'b1; c = cyc;
    push(4'h2, 4'h0, c + 10, c + 10);
    wait_idle(20);
    tick(2);
    c = cyc;
    for (int k = 0; k <= 10; k++) begin
      in_r[1] = k[0];
      if (k < 10) tick(3);
    end
    push(4'h0, 4'h2, c + 40, c + 40);
    wait_idle(30);

    // Simultaneous rise on ch2 and fall on ch3.
    in_r[3] = 1'b1; c = cyc;
    push(4'h8, 4'h0, c + 10, c + 10);
    wait_idle(20);
    in_r[2] = 1'b1; in_r[3] = 1'b0; c = cyc;
    push(4'h4, 4'h8, c + 10, c + 10);
    wait_idle(20);
    in_r[2] = 1'b0; c = cyc;
    push(4'h0, 4'h4, c + 10, c + 10);
    wait_idle(20);
    check("clear_level", o_level, 4'h0);

    // Reset in the middle of a count discards it.
    in_r[0] = 1'b1;
    tick(5);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_level", o_level, 4'h0);
    check("midrst_pulse", {o_rise, o_fall}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1; c = cyc;
    push(4'h1, 4'h0, c + 10, c + 10);
    wait_idle(20);
    in_r[0] = 1'b0; c = cyc;
    push(4'h0, 4'h1, c + 10, c + 10);
    wait_idle(20);
    tick(12);
    check("final_level", o_level, 4'h0);
`endif
    check("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
